// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: bus request/response, redirect input and the IF/ID output handshake.
// The master modport is the prefetch queue; the slave modport is its environment.
interface if_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic              req_valid;
  logic [XLEN-1:0]   req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic [XLEN-1:0]   out_inst;
  logic [XLEN-1:0]   out_pc;
  logic              out_ready;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    output req_valid, req_addr, out_valid, out_inst, out_pc, occupancy,
    input  req_ready, rsp_valid, rsp_data, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  req_valid, req_addr, out_valid, out_inst, out_pc, occupancy,
    output req_ready, rsp_valid, rsp_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// In-order instruction prefetch queue: credit-limited fetch issue, PC tag FIFO for
// in-flight requests, DEPTH-entry instruction buffer, redirect flush with response drop.
module if_prefetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic                 clk,
  input logic                 rst,
  if_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t          q_mem   [DEPTH];
  logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   occ;
  logic [TW-1:0]   tag_rd, tag_wr;
  logic [OW-1:0]   outstanding, drop_cnt;
  logic [XLEN-1:0] fetch_pc;

  logic credit_ok, hs, rsp_ok, push, pop;

  // Tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    credit_ok = (int'(occ) + int'(outstanding) < DEPTH) &&
                (int'(outstanding) < MAX_OUTSTANDING);
    // Gated by rst so the request stays low while reset is held.
    bus.req_valid = rst && !bus.redirect && credit_ok;
    bus.req_addr  = fetch_pc;
    hs            = bus.req_valid && bus.req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok        = bus.rsp_valid && (outstanding != '0);
    push          = rsp_ok && !bus.redirect && (drop_cnt == '0);
    bus.out_valid = (occ != '0);
    pop           = bus.out_valid && bus.out_ready && !bus.redirect;
    bus.out_inst  = bus.out_valid ? q_mem[rd_ptr].inst : '0;
    bus.out_pc    = bus.out_valid ? q_mem[rd_ptr].pc   : '0;
    bus.occupancy = occ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      occ         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (hs) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        tag_wr   <= tag_inc(tag_wr);
      end
      if (rsp_ok) tag_rd <= tag_inc(tag_rd);
      if (hs && !rsp_ok)      outstanding <= outstanding + 1'b1;
      else if (!hs && rsp_ok) outstanding <= outstanding - 1'b1;

      if (bus.redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding - OW'(rsp_ok);
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      occ <= occ + 1'b1;
        else if (!push && pop) occ <= occ - 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; visibility is governed by occ and the tag pointers.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{pc: tag_mem[tag_rd], inst: bus.rsp_data};
    if (hs)   tag_mem[tag_wr] <= fetch_pc;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    !(bus.rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed scenarios plus random traffic against a queue-based model of the fetch front end.
module tb_if_prefetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Model: requests on the bus in issue order (stale once redirected past), and the buffer.
  typedef struct { logic [31:0] pc; logic stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  fl_t         fl[$];
  ent_t        oq[$];
  logic [31:0] m_pc;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic erv);
    chk("req_valid", {31'b0, bus.req_valid}, {31'b0, erv});
    chk("req_addr",  bus.req_addr, m_pc);
    chk("out_valid", {31'b0, bus.out_valid}, (oq.size() != 0) ? 32'd1 : 32'd0);
    chk("out_pc",    bus.out_pc,   (oq.size() != 0) ? oq[0].pc   : 32'h0);
    chk("out_inst",  bus.out_inst, (oq.size() != 0) ? oq[0].inst : 32'h0);
    chk("occupancy", {29'b0, bus.occupancy}, oq.size());
  endtask

  task automatic idle_inputs();
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
    bus.redirect  = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
  endtask

  // Asserts reset at the current time, checks outputs before any edge, releases on a negedge.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    fl.delete(); oq.delete(); m_pc = RPC;
    #1;
    chk_all(1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle, entered and left on a negedge.
  task automatic step(input logic rdy, input logic rv, input logic redir,
                      input logic [31:0] rpc, input logic ordy, input logic [31:0] data);
    logic erv, rvv, hs, pop;
    fl_t  t;
    rvv = rv && (fl.size() != 0);
    bus.req_ready = rdy; bus.rsp_valid = rvv; bus.rsp_data = data;
    bus.redirect = redir; bus.redirect_pc = rpc; bus.out_ready = ordy;
    #1;
    erv = !redir && (oq.size() + fl.size() < DEPTH) && (fl.size() < MAXO);
    chk_all(erv);
    @(posedge clk);
    hs  = erv && rdy;
    pop = (oq.size() != 0) && ordy && !redir;
    if (pop) void'(oq.pop_front());
    if (rvv) begin
      t = fl.pop_front();
      if (!redir && !t.stale) oq.push_back('{pc: t.pc, inst: data});
    end
    if (hs) begin
      fl.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      oq.delete();
      foreach (fl[i]) fl[i].stale = 1'b1;
      m_pc = rpc & ~32'h3;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    m_pc = RPC;
    @(negedge clk);
    do_reset();

    // Streaming with single-cycle responses and a consumer that is always ready.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h0000_0013);
      chk("stream_occ_le1", {31'b0, (bus.occupancy <= 1)}, 32'd1);
    end

    // Stalled consumer fills the queue, then one pop frees a credit a cycle later.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, $urandom);
    chk("fill_occ", {29'b0, bus.occupancy}, 32'd4);
    chk("fill_req_valid", {31'b0, bus.req_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    chk("pop_occ", {29'b0, bus.occupancy}, 32'd3);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("refill_occ", {29'b0, bus.occupancy}, 32'd3);

    // Redirect with two requests in flight; both responses must be dropped.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h103, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 32'hDEAD_0020);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 32'hDEAD_0024);
    chk("drop_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("redir_addr", bus.req_addr, 32'h100);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h0000_0013);
    chk("redir_first_pc", bus.out_pc, 32'h100);

    // Redirect coinciding with a response while two entries are buffered.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 32'h1111_0000);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 32'h1111_0004);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("pre_redir_occ", {29'b0, bus.occupancy}, 32'd2);
    step(1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h1111_0008);
    chk("redir_rsp_occ", {29'b0, bus.occupancy}, 32'd0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 32'h1111_000C);
    chk("redir_rsp_dropped", {31'b0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1, $urandom);

    // Fetch PC wraps at the top of the address space.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("wrap_addr", bus.req_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 32'h0000_0013);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a burst, between clock edges.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("burst_occ", {29'b0, bus.occupancy}, 32'd2);
    #2;
    do_reset();
    chk("arst_occ", {29'b0, bus.occupancy}, 32'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("arst_addr", bus.req_addr, RPC);

    // Random traffic: ready-heavy consumer, then a mostly stalled one.
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0, $urandom,
           ($urandom % 3) != 0, $urandom);
    for (int i = 0; i < 1000; i++)
      step(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 24) == 0, $urandom,
           ($urandom % 5) == 0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
